vram_arbiter: RTL and testbench

- Shares the single-port synchronous VRAM (11-bit address, 8-bit data, 1-cycle read latency) between the CPU bus and the video character fetch.
- Video fetch has priority; a starvation guard forces a CPU slot after STARVE_LIMIT consecutive denials. The video fetch lost in that slot is flagged so the display can blank it.
- Sits between cobra1 core logic and the vram instance, in place of the direct v_ram_a/v_ram_do/v_ram_w connection.

---
 rtl/cobra1_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 27 ++
 rtl/vram_arbiter.sv | 82 ++++++++
 tb/tb_vram_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cobra1_pkg.sv
// Shared types for the cobra1 VRAM arbitration slice.
// Owner encoding and starvation counter width.
package cobra1_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_VID
    } owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the CPU was refused the VRAM.
// at_limit tells the arbiter the CPU must win the next conflict.
module arb_starve_ctr
    import cobra1_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] limit,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_limit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < limit)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt >= limit);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM sharing between CPU bus and video character fetch.
// Video wins conflicts unless the CPU has been refused STARVE_LIMIT times.
module vram_arbiter
    import cobra1_pkg::*;
#(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_a,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_a,
    output logic                  vid_valid,
    output logic                  vid_miss,
    output logic [DATA_WIDTH-1:0] vid_rd,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_do,
    output logic                  mem_w,
    input  logic [DATA_WIDTH-1:0] mem_di
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    owner_t                grant;
    owner_t                owner_q;
    logic                  we_q;
    logic                  miss_q;
    logic                  at_limit;
    logic [STARVE_W-1:0]   starve_cnt_unused;

    arb_starve_ctr u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (cpu_req && !cpu_gnt),
        .clr      (cpu_gnt || !cpu_req),
        .limit    (LIMIT),
        .cnt      (starve_cnt_unused),
        .at_limit (at_limit)
    );

    always_comb begin
        grant = OWN_NONE;
        if (cpu_req && (!vid_req || at_limit)) begin
            grant = OWN_CPU;
        end else if (vid_req) begin
            grant = OWN_VID;
        end
    end

    // Strobes are masked in reset so a held request cannot write the RAM.
    assign cpu_gnt = rst_n && (grant == OWN_CPU);
    assign mem_w   = cpu_gnt && cpu_we;
    assign mem_a   = (grant == OWN_CPU) ? cpu_a : vid_a;
    assign mem_do  = cpu_wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            owner_q <= grant;
            we_q    <= cpu_we;
            miss_q  <= vid_req && (grant == OWN_CPU);
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU) && !we_q;
    assign vid_valid  = (owner_q == OWN_VID);
    assign vid_miss   = miss_q;
    assign cpu_rd     = mem_di;
    assign vid_rd     = mem_di;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and random checks of vram_arbiter against a cycle-level
// reference built from the arbitration and read-latency rules.
module tb_vram_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_wd;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rd;
    logic          vid_req;
    logic [AW-1:0] vid_a;
    logic          vid_valid;
    logic          vid_miss;
    logic [DW-1:0] vid_rd;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_do;
    logic          mem_w;
    logic [DW-1:0] mem_di;

    logic [DW-1:0] vram    [0:2047];
    logic [DW-1:0] ref_mem [0:2047];
    int            waits;
    int            n_assert = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_a      (cpu_a),
        .cpu_wd     (cpu_wd),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rd     (cpu_rd),
        .vid_req    (vid_req),
        .vid_a      (vid_a),
        .vid_valid  (vid_valid),
        .vid_miss   (vid_miss),
        .vid_rd     (vid_rd),
        .mem_a      (mem_a),
        .mem_do     (mem_do),
        .mem_w      (mem_w),
        .mem_di     (mem_di)
    );

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk) begin
        mem_di <= vram[mem_a];
        if (mem_w) vram[mem_a] <= mem_do;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic creq, input logic cwe,
                        input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                        input logic vreq, input logic [AW-1:0] va,
                        output logic gnt);
        logic          e_cpu;
        logic          e_vid;
        logic          e_crv;
        logic [DW-1:0] e_cd;
        logic [DW-1:0] e_vd;
        @(negedge clk);
        cpu_req = creq;
        cpu_we  = cwe;
        cpu_a   = ca;
        cpu_wd  = cwd;
        vid_req = vreq;
        vid_a   = va;
        e_cpu = creq && (!vreq || waits >= LIM);
        e_vid = vreq && !e_cpu;
        #1;
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
        chk("mem_w", 32'(mem_w), 32'(e_cpu && cwe));
        chk("mem_a", 32'(mem_a), 32'(e_cpu ? ca : va));
        if (e_cpu && cwe) chk("mem_do", 32'(mem_do), 32'(cwd));
        e_crv = e_cpu && !cwe;
        e_cd  = ref_mem[ca];
        e_vd  = ref_mem[va];
        if (e_cpu && cwe) ref_mem[ca] = cwd;
        if (creq && !e_cpu) waits = (waits < LIM) ? waits + 1 : LIM;
        else waits = 0;
        gnt = e_cpu;
        @(posedge clk);
        #1;
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        chk("vid_valid", 32'(vid_valid), 32'(e_vid));
        chk("vid_miss", 32'(vid_miss), 32'(vreq && e_cpu));
        if (e_crv) chk("cpu_rd", 32'(cpu_rd), 32'(e_cd));
        if (e_vid) chk("vid_rd", 32'(vid_rd), 32'(e_vd));
    endtask

    initial begin
        logic          g;
        logic          pend;
        logic          pwe;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int            gc;

        rst_n   = 1'b0;
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        cpu_a   = 11'h123;
        cpu_wd  = 8'hEE;
        vid_req = 1'b0;
        vid_a   = 11'h000;
        waits   = 0;

        // Reset state with a write request held: nothing may leak out.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
        chk("rst_vid_valid", 32'(vid_valid), 32'(0));
        chk("rst_vid_miss", 32'(vid_miss), 32'(0));
        chk("rst_mem_w", 32'(mem_w), 32'(0));
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'(0));
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        rst_n   = 1'b1;

        step(0, 0, 0, 0, 0, 11'h2A5, g);

        for (int i = 0; i < 64; i++)
            step(1, 1, AW'(i), DW'($urandom), 0, 0, g);

        step(1, 1, 11'h123, 8'h5A, 0, 0, g);
        step(1, 0, 11'h123, 8'h00, 0, 0, g);
        chk("rd_5a", 32'(cpu_rd), 32'(8'h5A));
        step(1, 1, 11'h010, 8'h41, 0, 0, g);
        step(1, 1, 11'h001, 8'h11, 0, 0, g);
        step(1, 1, 11'h002, 8'h22, 0, 0, g);

        // Continuous video load against one CPU read.
        gc = 0;
        for (int k = 1; k <= 7; k++) begin
            step(gc == 0, 0, 11'h123, 0, 1, 11'h010, g);
            if (g && gc == 0) gc = k;
        end
        chk("starve_grant_cycle", 32'(gc), 32'(LIM + 1));

        // Same-cycle rise: video first, CPU held until granted.
        gc = 0;
        for (int k = 1; k <= 8 && gc == 0; k++) begin
            step(1, 0, 11'h002, 0, 1, 11'h001, g);
            if (g) gc = k;
        end
        chk("rise_grant_cycle", 32'(gc), 32'(LIM + 1));

        step(1, 0, 11'h001, 0, 0, 0, g);
        chk("b2b_rd0", 32'(cpu_rd), 32'(8'h11));
        step(1, 0, 11'h002, 0, 0, 0, g);
        chk("b2b_rd1", 32'(cpu_rd), 32'(8'h22));
        step(1, 0, 11'h003, 0, 0, 0, g);
        step(1, 1, 11'h003, 8'hC3, 0, 0, g);
        step(1, 0, 11'h003, 0, 0, 0, g);
        chk("raw_new", 32'(cpu_rd), 32'(8'hC3));

        // Reset arriving right after a read grant.
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_a   = 11'h001;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(cpu_rvalid), 32'(0));
        chk("mid_rst_gnt", 32'(cpu_gnt), 32'(0));
        @(negedge clk);
        cpu_we = 1'b1;
        #1;
        chk("mid_rst_mem_w", 32'(mem_w), 32'(0));
        @(negedge clk);
        #1;
        chk("mid_rst_mem_w2", 32'(mem_w), 32'(0));
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        rst_n   = 1'b1;
        waits   = 0;
        step(0, 0, 0, 0, 0, 11'h005, g);

        gc = 0;
        for (int k = 1; k <= 8 && gc == 0; k++) begin
            step(1, 0, 11'h004, 0, 1, 11'h006, g);
            if (g) gc = k;
        end
        chk("post_rst_grant_cycle", 32'(gc), 32'(LIM + 1));

        // Random traffic over the preloaded window.
        pend = 1'b0;
        pwe  = 1'b0;
        pa   = '0;
        pd   = '0;
        for (int n = 0; n < 500; n++) begin
            if (!pend && ($urandom_range(1) == 1)) begin
                pend = 1'b1;
                pwe  = 1'($urandom_range(1));
                pa   = AW'($urandom_range(63));
                pd   = DW'($urandom);
            end
            step(pend, pwe, pa, pd, $urandom_range(3) != 0,
                 AW'($urandom_range(63)), g);
            if (g) pend = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
